vedic_add_sequencer: RTL and testbench

- Time-multiplexed controller for one shared 64-bit ripple-carry adder (A, B, cin in; SUM, cout out).
- Combines the four 64-bit partial products of a 64x64 Vedic (Urdhva-Tiryagbhyam) multiplier into the 128-bit product: P = LL + ((LH + HL) << 32) + (HH << 64).
- Needs three adder passes; one adder is reused instead of a 128-bit adder tree.
- Sits between the 32x32 sub-multiplier array and the product register.

---
 rtl/vedic_add_sequencer_if.sv | 28 ++
 rtl/vedic_add_sequencer.sv | 148 ++++++++++++++
 tb/tb_vedic_add_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/vedic_add_sequencer_if.sv
// Handshake/bus bundle between the sub-multiplier array, the shared 64-bit adder and
// vedic_add_sequencer. The sequencer uses the slave modport.
interface vedic_add_sequencer_if;
  logic         start;
  logic [63:0]  PP_LL;
  logic [63:0]  PP_LH;
  logic [63:0]  PP_HL;
  logic [63:0]  PP_HH;
  logic [63:0]  ADD_A;
  logic [63:0]  ADD_B;
  logic         add_cin;
  logic [63:0]  ADD_SUM;
  logic         add_cout;
  logic         busy;
  logic         done;
  logic [127:0] PRODUCT;
  logic         err;

  modport slave (
    input  start, PP_LL, PP_LH, PP_HL, PP_HH, ADD_SUM, add_cout,
    output ADD_A, ADD_B, add_cin, busy, done, PRODUCT, err
  );

  modport master (
    output start, PP_LL, PP_LH, PP_HL, PP_HH, ADD_SUM, add_cout,
    input  ADD_A, ADD_B, add_cin, busy, done, PRODUCT, err
  );
endinterface

// File: rtl/vedic_add_sequencer.sv
// Folds the four 64-bit Vedic partial products into a 128-bit product using three passes
// through one shared 64-bit adder. Optional overflow check: define VEDIC_SEQ_CHECK_EN.
module vedic_add_sequencer #(
  parameter int unsigned ADD_WAIT = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  vedic_add_sequencer_if.slave bus
);

  localparam logic [3:0] WaitInit = 4'(ADD_WAIT);

  typedef enum logic [2:0] {StIdle, StAddMid, StAddLo, StAddHi, StDone} state_e;

  state_e       state_q;
  logic [3:0]   wait_q;
  logic [63:0]  ll_q, lh_q, hl_q, hh_q;
  logic [63:0]  m_q;
  logic         mc_q;
  logic         c2_q;
  logic [127:0] product_q;
  logic         busy_q;
  logic         done_q;
  logic         last;
  logic [63:0]  add_a;
  logic [63:0]  add_b;
  logic         add_cin;

  // Adder result is sampled only on the final cycle of each multicycle pass.
  assign last = (wait_q == 4'd0);

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      StAddMid: begin
        add_a = lh_q;
        add_b = hl_q;
      end
      StAddLo: begin
        add_a = {hh_q[31:0], ll_q[63:32]};
        add_b = m_q;
      end
      StAddHi: begin
        add_a   = {32'b0, hh_q[63:32]};
        add_b   = {63'b0, mc_q};
        add_cin = c2_q;
      end
      default: ;
    endcase
  end

  assign bus.ADD_A   = add_a;
  assign bus.ADD_B   = add_b;
  assign bus.add_cin = add_cin;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.PRODUCT = product_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wait_q    <= 4'd0;
      ll_q      <= '0;
      lh_q      <= '0;
      hl_q      <= '0;
      hh_q      <= '0;
      m_q       <= '0;
      mc_q      <= 1'b0;
      c2_q      <= 1'b0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            ll_q    <= bus.PP_LL;
            lh_q    <= bus.PP_LH;
            hl_q    <= bus.PP_HL;
            hh_q    <= bus.PP_HH;
            wait_q  <= WaitInit;
            busy_q  <= 1'b1;
            state_q <= StAddMid;
          end
        end
        StAddMid: begin
          if (last) begin
            m_q     <= bus.ADD_SUM;
            mc_q    <= bus.add_cout;
            wait_q  <= WaitInit;
            state_q <= StAddLo;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StAddLo: begin
          if (last) begin
            product_q[95:32] <= bus.ADD_SUM;
            product_q[31:0]  <= ll_q[31:0];
            c2_q             <= bus.add_cout;
            wait_q           <= WaitInit;
            state_q          <= StAddHi;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StAddHi: begin
          if (last) begin
            product_q[127:96] <= bus.ADD_SUM[31:0];
            state_q           <= StDone;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef VEDIC_SEQ_CHECK_EN
  logic err_q;

  // The final pass can never legitimately carry past bit 31; a carry there is a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && bus.start) begin
      err_q <= 1'b0;
    end else if (state_q == StAddHi && last &&
                 (bus.ADD_SUM[63:32] != 32'd0 || bus.add_cout)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_vedic_add_sequencer.sv
// Directed bench for vedic_add_sequencer: one instance with ADD_WAIT=0, one with ADD_WAIT=3,
// each driving its own behavioural 64-bit adder.
module tb_vedic_add_sequencer;

  logic clk;
  logic rst_n;
  logic force0;
  int   n_checks;
  int   n_err;

  vedic_add_sequencer_if b0 ();
  vedic_add_sequencer_if b3 ();

  vedic_add_sequencer #(.ADD_WAIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  vedic_add_sequencer #(.ADD_WAIT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    {b0.add_cout, b0.ADD_SUM} = {1'b0, b0.ADD_A} + {1'b0, b0.ADD_B} + {64'd0, b0.add_cin};
    if (force0) b0.add_cout = 1'b1;
  end

  always_comb begin
    {b3.add_cout, b3.ADD_SUM} = {1'b0, b3.ADD_A} + {1'b0, b3.ADD_B} + {64'd0, b3.add_cin};
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? b3.done : b0.done;
  endfunction

  // Drives operands and a one-cycle start; returns at the negedge after the accepting edge.
  task automatic launch(input bit sel, input logic [63:0] ll, input logic [63:0] lh,
                        input logic [63:0] hl, input logic [63:0] hh);
    @(negedge clk);
    if (sel) begin
      b3.PP_LL = ll; b3.PP_LH = lh; b3.PP_HL = hl; b3.PP_HH = hh; b3.start = 1'b1;
    end else begin
      b0.PP_LL = ll; b0.PP_LH = lh; b0.PP_HL = hl; b0.PP_HH = hh; b0.start = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    b0.start = 1'b0;
    b3.start = 1'b0;
  endtask

  // Counts clock edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(input bit sel, input int already, output int lat);
    lat = -1;
    for (int k = already + 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_done(sel)) begin
        lat = k;
        break;
      end
    end
  endtask

  localparam logic [63:0] AllF = 64'hFFFF_FFFE_0000_0001;

  initial begin
    int lat;
    int pulses;
    logic exp_err;
    n_checks = 0;
    n_err    = 0;
    force0   = 1'b0;
    rst_n    = 1'b0;
    b0.start = 1'b0; b0.PP_LL = '0; b0.PP_LH = '0; b0.PP_HL = '0; b0.PP_HH = '0;
    b3.start = 1'b0; b3.PP_LL = '0; b3.PP_LH = '0; b3.PP_HL = '0; b3.PP_HH = '0;
`ifdef VEDIC_SEQ_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check_eq("rst_busy", b0.busy, 0);
    check_eq("rst_done", b0.done, 0);
    check_eq("rst_product", b0.PRODUCT, 0);
    check_eq("rst_add_a", b0.ADD_A, 0);
    check_eq("rst_err", b0.err, 0);
    rst_n = 1'b1;

    // All-ones operands, ADD_WAIT=0.
    launch(0, AllF, AllF, AllF, AllF);
    check_eq("mid_busy", b0.busy, 1);
    check_eq("mid_add_a", b0.ADD_A, AllF);
    check_eq("mid_add_b", b0.ADD_B, AllF);
    wait_done(0, 0, lat);
    check_eq("t1_latency", lat, 4);
    check_eq("t1_product", b0.PRODUCT, 128'hFFFFFFFF_FFFFFFFE_00000000_00000001);
    check_eq("t1_busy_at_done", b0.busy, 0);
    check_eq("t1_err", b0.err, 0);
    check_eq("t1_idle_add_a", b0.ADD_A, 0);
    @(negedge clk);
    check_eq("t1_done_one_cycle", b0.done, 0);
    check_eq("t1_product_held", b0.PRODUCT, 128'hFFFFFFFF_FFFFFFFE_00000000_00000001);

    // Only LL nonzero: middle sum is zero with no carry.
    launch(0, 64'd5, 64'd0, 64'd0, 64'd0);
    check_eq("t2_mid_sum", b0.ADD_SUM, 0);
    check_eq("t2_mid_cout", b0.add_cout, 0);
    wait_done(0, 0, lat);
    check_eq("t2_latency", lat, 4);
    check_eq("t2_product", b0.PRODUCT, 128'h5);

    // Middle carry out, ADD_WAIT=3.
    launch(1, 64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0);
    wait_done(1, 0, lat);
    check_eq("t3_latency", lat, 13);
    check_eq("t3_product", b3.PRODUCT, 128'h1_00000000_00000000_00000000);

    // Start while busy with other operands must be ignored.
    launch(0, 64'd9, 64'd1, 64'd1, 64'd0);
    b0.PP_LL = AllF; b0.PP_LH = AllF; b0.PP_HL = AllF; b0.PP_HH = AllF;
    b0.start = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    b0.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (b0.done) pulses++;
    end
    check_eq("t4_done_pulses", pulses, 1);
    check_eq("t4_product", b0.PRODUCT, 128'h2_00000009);

    // Reset asserted during ADD_LO.
    launch(0, AllF, AllF, AllF, AllF);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_busy", b0.busy, 0);
    check_eq("t5_rst_done", b0.done, 0);
    check_eq("t5_rst_product", b0.PRODUCT, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b0.done) pulses++;
    end
    check_eq("t5_no_done", pulses, 0);
    launch(0, 64'd5, 64'd0, 64'd0, 64'd0);
    wait_done(0, 0, lat);
    check_eq("t5_product", b0.PRODUCT, 128'h5);

    // Carry forced out of the final pass.
    launch(0, 64'd5, 64'd0, 64'd0, 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    force0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    force0 = 1'b0;
    wait_done(0, 3, lat);
    check_eq("t6_latency", lat, 4);
    check_eq("t6_product", b0.PRODUCT, 128'h5);
    check_eq("t6_err_at_done", b0.err, exp_err);
    repeat (3) @(negedge clk);
    check_eq("t6_err_held", b0.err, exp_err);
    launch(0, 64'd5, 64'd0, 64'd0, 64'd0);
    check_eq("t6_err_cleared", b0.err, 0);
    wait_done(0, 0, lat);
    check_eq("t6_err_clean_run", b0.err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
